// File: rtl/data_ram_if.sv
// Data-side RAM request bus between the MEM stage (master) and the RAM responder (slave).
interface data_ram_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_busy;
  logic        ram_addr_err;

  // MEM stage: issues requests, consumes read data and stall.
  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_busy, ram_addr_err
  );

  // RAM responder: services requests.
  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_busy, ram_addr_err
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Data-side RAM responder: byte-writable word array with registered read data,
// optional wait states that stall the pipeline through ram_busy, and a one-cycle
// error pulse for accesses outside the mapped window.
module data_ram_ctrl #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst_n,
  data_ram_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   index;
  logic                    in_range;
  logic                    complete;
  logic                    busy;
  logic                    do_write;
  logic                    do_read;
  logic                    unused_addr_lsbs;

  // Alignment is the MEM stage's job; the low address bits carry no meaning here.
  assign unused_addr_lsbs = ^bus.ram_addr[1:0];

  assign index    = bus.ram_addr[ADDR_WIDTH+1:2];
  assign in_range = (bus.ram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  // Decide whether the current request completes at this edge or must stall.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    complete = 1'b0;
    busy     = 1'b0;
    if (rst_n && bus.ram_en) begin
      if (WAIT_STATES == 0) begin
        complete = 1'b1;
      end else if (state == ST_WAIT && wait_cnt == 4'd0) begin
        complete = 1'b1;
      end else begin
        busy = 1'b1;
      end
    end
  end

  assign do_write     = complete && in_range && (bus.ram_write_en != 4'b0000);
  assign do_read      = complete && (bus.ram_write_en == 4'b0000);
  assign bus.ram_busy = busy;

  // Wait-state sequencing plus the registered read data and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      wait_cnt          <= 4'd0;
      bus.ram_read_data <= 32'd0;
      bus.ram_addr_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      bus.ram_addr_err <= complete && !in_range;
      if (do_read) begin
        bus.ram_read_data <= in_range ? mem[index] : 32'd0;
      end
      case (state)
        ST_IDLE: begin
          if (bus.ram_en && WAIT_STATES != 0) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (!bus.ram_en || wait_cnt == 4'd0) begin
            // Flush or completion: either way the access is finished.
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane writes into the word array.
  // NOTE: the array has no reset; contents survive rst_n and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (do_write && bus.ram_write_en[k]) begin
        mem[index][8*k +: 8] <= bus.ram_write_data[8*k +: 8];
      end
    end
  end

endmodule
